// File: rtl/uart_tx_fifo_feeder.sv
// uart_tx_fifo_feeder: byte FIFO that feeds a single-byte UART transmitter
// through its data-valid / active / done handshake.
module uart_tx_fifo_feeder #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Wr_DV,
    input  logic [7:0]        i_Wr_Byte,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Overflow,
    output logic              o_Tx_DV,
    output logic [7:0]        o_Tx_Byte,
    input  logic              i_Tx_Active,
    input  logic              i_Tx_Done,
    output logic              o_Busy
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT_ACTIVE, S_WAIT_DONE, S_WAIT_CLR} state_t;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
    logic              tx_dv_q, tx_dv_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    state_t            state_q, state_d;
    logic              wr, pop;

    always_comb begin
        wr        = i_Wr_DV && !full_q;
        // Never hand over a byte while the transmitter still reports activity.
        pop       = state_q == S_IDLE && !empty_q && !i_Tx_Active && !i_Tx_Done;
        wr_ptr_d  = wr ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d   = count_q + (ADDR_W+1)'(wr) - (ADDR_W+1)'(pop);
        full_d    = count_d == (ADDR_W+1)'(DEPTH);
        empty_d   = count_d == '0;
        ovf_d     = ovf_q || (i_Wr_DV && full_q);
        tx_dv_d   = pop;
        tx_byte_d = pop ? mem[rd_ptr_q] : tx_byte_q;
        state_d   = state_q;
        case (state_q)
            S_IDLE:        state_d = pop ? S_WAIT_ACTIVE : S_IDLE;
            S_WAIT_ACTIVE: state_d = i_Tx_Active ? S_WAIT_DONE : S_WAIT_ACTIVE;
            S_WAIT_DONE:   state_d = i_Tx_Done ? S_WAIT_CLR : S_WAIT_DONE;
            S_WAIT_CLR:    state_d = i_Tx_Done ? S_WAIT_CLR : S_IDLE;
            default:       state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
            state_q   <= S_IDLE;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            state_q   <= state_d;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (wr) mem[wr_ptr_q] <= i_Wr_Byte;
    end

    assign o_Full     = full_q;
    assign o_Empty    = empty_q;
    assign o_Count    = count_q;
    assign o_Overflow = ovf_q;
    assign o_Tx_DV    = tx_dv_q;
    assign o_Tx_Byte  = tx_byte_q;
    assign o_Busy     = state_q != S_IDLE;
endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// tb_uart_tx_fifo_feeder: feeder driven by a behavioural 8N1 transmitter
// (4 clocks per bit); bytes are scoreboarded from write to transmitter load.
module tb_uart_tx_fifo_feeder;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 0, rst = 1;
    logic          i_Wr_DV = 0;
    logic [7:0]    i_Wr_Byte = 0;
    logic          o_Full, o_Empty, o_Overflow, o_Tx_DV, o_Busy;
    logic [AW:0]   o_Count;
    logic [7:0]    o_Tx_Byte;
    logic          hold = 0, tx_active, tx_done, tx_serial;
    logic [9:0]    m_frame;
    int            m_st, m_bit, m_cnt, dv_cnt, errs, checks;
    logic [7:0]    sb[$];

    always #5 clk = ~clk;

    uart_tx_fifo_feeder #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Wr_DV(i_Wr_DV), .i_Wr_Byte(i_Wr_Byte),
        .o_Full(o_Full), .o_Empty(o_Empty), .o_Count(o_Count), .o_Overflow(o_Overflow),
        .o_Tx_DV(o_Tx_DV), .o_Tx_Byte(o_Tx_Byte), .i_Tx_Active(tx_active | hold),
        .i_Tx_Done(tx_done), .o_Busy(o_Busy)
    );

    // Transmitter model: Done stays high for two cycles after the stop bit.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st <= 0; m_bit <= 0; m_cnt <= 0; tx_active <= 0; tx_done <= 0; tx_serial <= 1;
        end else if (m_st == 0) begin
            tx_serial <= 1;
            if (o_Tx_DV) begin
                m_frame <= {1'b1, o_Tx_Byte, 1'b0}; tx_active <= 1; m_st <= 1; m_bit <= 0; m_cnt <= 0;
            end
        end else if (m_st == 1) begin
            tx_serial <= m_frame[m_bit];
            if (m_cnt == 3) begin
                m_cnt <= 0;
                if (m_bit == 9) begin m_st <= 2; tx_active <= 0; tx_done <= 1; end
                else m_bit <= m_bit + 1;
            end else m_cnt <= m_cnt + 1;
        end else if (m_st == 2) m_st <= 3;
        else begin tx_done <= 0; m_st <= 0; end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && o_Tx_DV) begin
            dv_cnt <= dv_cnt + 1;
            check("dv_while_busy", {31'b0, tx_active | hold | tx_done}, 0);
            if (sb.size() == 0) check("dv_unexpected", 1, 0);
            else check("tx_byte", o_Tx_Byte, sb.pop_front());
        end
    end

    task automatic write(input logic [7:0] b, input bit accept);
        i_Wr_DV = 1; i_Wr_Byte = b;
        if (accept) sb.push_back(b);
        @(negedge clk);
        i_Wr_DV = 0;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 3000 && !(!o_Busy && o_Empty && m_st == 0 && sb.size() == 0); i++) @(negedge clk);
        check(tag, {31'b0, i < 3000}, 1);
    endtask

    initial begin
        int d0;
        errs = 0; checks = 0; dv_cnt = 0;
        repeat (3) @(negedge clk);
        check("rst_count", o_Count, 0);
        check("rst_flags", {o_Empty, o_Full, o_Overflow, o_Tx_DV, o_Busy}, 5'b10000);
        check("rst_byte", o_Tx_Byte, 0);
        rst = 0;
        @(negedge clk);
        write(8'hA5, 1);
        check("single_count", o_Count, 1);
        @(negedge clk);
        check("single_dv", {31'b0, o_Tx_DV}, 1);
        check("single_busy", {31'b0, o_Busy}, 1);
        wait_idle("single_idle");
        check("single_dv_cnt", dv_cnt, 1);
        check("single_hold_byte", o_Tx_Byte, 8'hA5);
        check("single_empty", {31'b0, o_Empty}, 1);
        d0 = dv_cnt;
        for (int i = 1; i <= 5; i++) write(8'(i), 1);
        wait_idle("burst_idle");
        check("burst_dv_cnt", dv_cnt - d0, 5);
        hold = 1;
        for (int i = 0; i < 17; i++) write(8'h20 + 8'(i), i < 16);
        check("full_count", o_Count, 16);
        check("full_flags", {o_Full, o_Empty, o_Overflow}, 3'b101);
        hold = 0; i_Wr_DV = 1; i_Wr_Byte = 8'hEE;
        @(negedge clk);
        i_Wr_DV = 0;
        check("full_pop_count", o_Count, 15);
        check("full_pop_ovf", {31'b0, o_Overflow}, 1);
        wait_idle("full_idle");
        check("ovf_sticky", {31'b0, o_Overflow}, 1);
        for (int i = 0; i < 12; i++) write(8'h40 + 8'(i), 1);
        wait_idle("wrap_a_idle");
        for (int i = 0; i < 12; i++) write(8'h10 + 8'(i), 1);
        wait_idle("wrap_b_idle");
        check("wrap_count", o_Count, 0);
        hold = 1;
        for (int i = 0; i < 3; i++) write(8'h50 + 8'(i), 1);
        hold = 0;
        write(8'h53, 1);
        check("pushpop_count", o_Count, 3);
        wait_idle("pushpop_idle");
        for (int i = 0; i < 5; i++) write(8'h60 + 8'(i), 1);
        for (int i = 0; i < 100 && !tx_active; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("mid_count", o_Count, 4);
        #1 rst = 1;
        sb.delete();
        #1;
        check("mid_rst_count", o_Count, 0);
        check("mid_rst_flags", {o_Empty, o_Full, o_Overflow, o_Tx_DV, o_Busy}, 5'b10000);
        check("mid_rst_byte", o_Tx_Byte, 0);
        @(negedge clk);
        rst = 0;
        d0 = dv_cnt;
        repeat (80) @(negedge clk);
        check("post_rst_no_dv", dv_cnt - d0, 0);
        check("post_rst_busy", {31'b0, o_Busy}, 0);
        write(8'h77, 1);
        wait_idle("post_rst_idle");
        check("post_rst_dv", dv_cnt - d0, 1);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
